// File: rtl/sd_card_sim.sv
// Behavioural SPI-mode SDHC card model: oversamples the host SPI bus on clk and serves
// CMD0/8/55/41/58/17/24 from an internal block store that survives reset and clear.
`timescale 1ns/1ps
module sd_card_sim #(
    parameter int unsigned MEM_BLOCKS = 64,
    parameter int unsigned NCR        = 1,
    parameter int unsigned READ_GAP   = 2,
    parameter int unsigned BUSY_BYTES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sdCS,
    input  logic sdSCLK,
    input  logic sdMOSI,
    output logic sdMISO
);
    localparam int unsigned AW = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
    localparam logic [2:0] ST_WAIT_CMD = 3'd0, ST_CMD_ARG = 3'd1, ST_RESP = 3'd2,
                           ST_READ = 3'd3, ST_WR_TOKEN = 3'd4, ST_WR_DATA = 3'd5,
                           ST_BUSY = 3'd6;
    localparam logic [9:0] READ_LEN = 10'(READ_GAP + 515);

    logic [1:0]    r_cs_s, r_sclk_s, r_mosi_s;
    logic          r_sclk_d;
    logic [2:0]    r_state, r_nxt, w_state_d, w_nxt_d;
    logic [9:0]    r_cnt, w_cnt_d;
    logic [2:0]    r_bit_cnt, w_bit_d;
    logic [6:0]    r_in_sh, w_in_d;
    logic [7:0]    r_out_sh, w_out_d;
    logic          r_miso, w_miso_d;
    logic [5:0]    r_cmd, w_cmd_d;
    logic [31:0]   r_arg, w_arg_d;
    logic [39:0]   r_resp, w_resp_d;
    logic [2:0]    r_len, w_len_d;
    logic [AW-1:0] r_blk, w_blk_d;
    logic          r_init, w_init_d, r_app, w_app_d, r_acmd, w_acmd_d;
    logic [7:0]    r_mem [0:MEM_BLOCKS*512-1];
    logic [7:0]    w_r1, w_rx;
    logic [8:0]    w_off;
    logic          w_rise, w_fall, w_byte_done, w_we;

    assign w_rise      = r_sclk_s[1] & ~r_sclk_d;
    assign w_fall      = ~r_sclk_s[1] & r_sclk_d;
    assign w_rx        = {r_in_sh, r_mosi_s[1]};
    assign w_byte_done = ~r_cs_s[1] & w_rise & (r_bit_cnt == 3'd7);
    assign w_we        = w_byte_done & (r_state == ST_WR_DATA) & (r_cnt < 10'd512);
    assign sdMISO      = r_miso;

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            r_cs_s   <= 2'b11;
            r_sclk_s <= 2'b00;
            r_mosi_s <= 2'b11;
            r_sclk_d <= 1'b0;
        end else begin
            r_cs_s   <= {r_cs_s[0], sdCS};
            r_sclk_s <= {r_sclk_s[0], sdSCLK};
            r_mosi_s <= {r_mosi_s[0], sdMOSI};
            r_sclk_d <= r_sclk_s[1];
        end
    end

    always_comb begin
        w_state_d = r_state;  w_nxt_d = r_nxt;   w_cnt_d = r_cnt;     w_bit_d = r_bit_cnt;
        w_in_d    = r_in_sh;  w_out_d = r_out_sh; w_miso_d = r_miso;  w_cmd_d = r_cmd;
        w_arg_d   = r_arg;    w_resp_d = r_resp; w_len_d = r_len;     w_blk_d = r_blk;
        w_init_d  = r_init;   w_app_d = r_app;   w_acmd_d = r_acmd;
        w_r1      = 8'h00;    w_off = '0;
        if (r_cs_s[1]) begin
            w_state_d = ST_WAIT_CMD;
            w_bit_d   = '0;
            w_out_d   = 8'hFF;
            w_miso_d  = 1'b1;
        end else begin
            if (w_fall) begin
                w_miso_d = r_out_sh[7];
                w_out_d  = {r_out_sh[6:0], 1'b1};
            end
            if (w_rise) begin
                w_in_d  = w_rx[6:0];
                w_bit_d = r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
                w_out_d = 8'hFF;
                case (r_state)
                    ST_WAIT_CMD: if (w_rx[7:6] == 2'b01) begin
                        w_cmd_d   = w_rx[5:0];
                        w_cnt_d   = '0;
                        w_state_d = ST_CMD_ARG;
                    end
                    ST_CMD_ARG: if (r_cnt < 10'd4) begin
                        w_arg_d = {r_arg[23:0], w_rx};
                        w_cnt_d = r_cnt + 10'd1;
                    end else begin
                        // CRC byte just arrived: decode and queue the response
                        w_state_d = ST_RESP;
                        w_cnt_d   = '0;
                        w_nxt_d   = ST_WAIT_CMD;
                        w_len_d   = 3'd1;
                        w_app_d   = 1'b0;
                        w_blk_d   = AW'(r_arg % MEM_BLOCKS);
                        w_r1      = {7'd0, ~r_init};
                        case (r_cmd)
                            6'd0: begin
                                w_r1 = 8'h01;  w_init_d = 1'b0;  w_acmd_d = 1'b0;
                            end
                            6'd55: w_app_d = 1'b1;
                            6'd41: if (!r_app)       w_r1 = {5'd0, 1'b1, 1'b0, ~r_init};
                                   else if (r_acmd) begin w_r1 = 8'h00; w_init_d = 1'b1; end
                                   else begin w_r1 = 8'h01; w_acmd_d = 1'b1; end
                            6'd8, 6'd58: w_len_d = 3'd5;
                            6'd17: if (r_init) w_nxt_d = ST_READ;     else w_r1 = 8'h05;
                            6'd24: if (r_init) w_nxt_d = ST_WR_TOKEN; else w_r1 = 8'h05;
                            default: w_r1 = {5'd0, 1'b1, 1'b0, ~r_init};
                        endcase
                        if (r_cmd == 6'd8)
                            w_resp_d = {w_r1, 16'h0000, 4'h0, r_arg[11:0]};
                        else if (r_cmd == 6'd58)
                            w_resp_d = {w_r1, 32'hC0FF_8000};
                        else
                            w_resp_d = {w_r1, 32'h0};
                    end
                    ST_RESP: if (r_cnt == 10'(NCR) + 10'(r_len)) begin
                        w_state_d = r_nxt;
                        w_cnt_d   = '0;
                    end
                    ST_READ: if (r_cnt == READ_LEN) w_state_d = ST_WAIT_CMD;
                    ST_WR_TOKEN: if (w_rx == 8'hFE) begin
                        w_state_d = ST_WR_DATA;
                        w_cnt_d   = '0;
                    end
                    ST_WR_DATA: if (r_cnt == 10'd513) begin
                        w_state_d = ST_BUSY;
                        w_cnt_d   = '0;
                        w_out_d   = 8'h05;
                    end else begin
                        w_cnt_d = r_cnt + 10'd1;
                    end
                    ST_BUSY: if (r_cnt < 10'(BUSY_BYTES)) begin
                        w_out_d = 8'h00;
                        w_cnt_d = r_cnt + 10'd1;
                    end else begin
                        w_state_d = ST_WAIT_CMD;
                    end
                    default: w_state_d = ST_WAIT_CMD;
                endcase
                // Byte streams indexed by position: NCR fill then response; gap/token/data/CRC
                if (w_state_d == ST_RESP) begin
                    if (w_cnt_d >= 10'(NCR)) begin
                        w_out_d  = w_resp_d[39:32];
                        w_resp_d = {w_resp_d[31:0], 8'hFF};
                    end
                    w_cnt_d = w_cnt_d + 10'd1;
                end else if (w_state_d == ST_READ) begin
                    w_off = 9'(w_cnt_d - 10'(READ_GAP + 1));
                    if (w_cnt_d == 10'(READ_GAP))
                        w_out_d = 8'hFE;
                    else if (w_cnt_d > 10'(READ_GAP) && w_cnt_d < 10'(READ_GAP + 513))
                        w_out_d = r_mem[{r_blk, w_off}];
                    w_cnt_d = w_cnt_d + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            r_state <= ST_WAIT_CMD; r_nxt <= ST_WAIT_CMD; r_cnt <= '0;    r_bit_cnt <= '0;
            r_in_sh <= '0;          r_out_sh <= 8'hFF;    r_miso <= 1'b1; r_cmd <= '0;
            r_arg   <= '0;          r_resp <= '0;         r_len <= 3'd1;  r_blk <= '0;
            r_init  <= 1'b0;        r_app <= 1'b0;        r_acmd <= 1'b0;
        end else begin
            r_state <= w_state_d;   r_nxt <= w_nxt_d;     r_cnt <= w_cnt_d; r_bit_cnt <= w_bit_d;
            r_in_sh <= w_in_d;      r_out_sh <= w_out_d;  r_miso <= w_miso_d; r_cmd <= w_cmd_d;
            r_arg   <= w_arg_d;     r_resp <= w_resp_d;   r_len <= w_len_d;  r_blk <= w_blk_d;
            r_init  <= w_init_d;    r_app <= w_app_d;     r_acmd <= w_acmd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[{r_blk, r_cnt[8:0]}] <= w_rx;
    end
endmodule

// File: tb/tb_sd_card_sim.sv
// Directed SPI host bench for sd_card_sim: init handshake, write/read-back, clear and
// mid-read deselect, each byte checked against hand-derived card responses.
`timescale 1ns/1ps
module tb_sd_card_sim;
    logic clk = 1'b0;
    logic reset, clear, sdCS, sdSCLK, sdMOSI;
    logic sdMISO;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] rx;

    always #5 clk = ~clk;

    sd_card_sim dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .sdCS   (sdCS),
        .sdSCLK (sdSCLK),
        .sdMOSI (sdMOSI),
        .sdMISO (sdMISO)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI mode 0, 3 clk per phase; MISO sampled just before each rise
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] got);
        got = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            sdMOSI = tx[7-i];
            repeat (3) @(negedge clk);
            got[7-i] = sdMISO;
            sdSCLK = 1'b1;
            repeat (3) @(negedge clk);
            sdSCLK = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] c, input logic [31:0] a, input logic [7:0] crc);
        logic [7:0] d;
        xfer({2'b01, c}, 8, d);
        for (int i = 3; i >= 0; i--) xfer(a[8*i +: 8], 8, d);
        xfer(crc, 8, d);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        xfer(8'hFF, 8, d);
        chk(tag, d, exp);
    endtask

    task automatic init_card();
        send_cmd(6'd55, 32'h0, 8'h65);       expect_byte("c55a_ncr", 8'hFF);
        expect_byte("c55a_r1", 8'h01);
        send_cmd(6'd41, 32'h4000_0000, 8'h77); expect_byte("a41a_ncr", 8'hFF);
        expect_byte("a41a_r1", 8'h01);
        send_cmd(6'd55, 32'h0, 8'h65);       expect_byte("c55b_ncr", 8'hFF);
        expect_byte("c55b_r1", 8'h01);
        send_cmd(6'd41, 32'h4000_0000, 8'h77); expect_byte("a41b_ncr", 8'hFF);
        expect_byte("a41b_r1", 8'h00);
    endtask

    task automatic read_head();
        send_cmd(6'd17, 32'd3, 8'hFF);
        expect_byte("rd_ncr", 8'hFF);
        expect_byte("rd_r1", 8'h00);
        expect_byte("rd_gap0", 8'hFF);
        expect_byte("rd_gap1", 8'hFF);
        expect_byte("rd_token", 8'hFE);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; sdCS = 1'b1; sdSCLK = 1'b0; sdMOSI = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_miso", {7'd0, sdMISO}, 8'h01);
        sdCS = 1'b0;
        repeat (4) @(negedge clk);

        send_cmd(6'd0, 32'h0, 8'h95);
        expect_byte("cmd0_ncr", 8'hFF);
        expect_byte("cmd0_r1", 8'h01);
        expect_byte("cmd0_after", 8'hFF);

        send_cmd(6'd8, 32'h0000_01AA, 8'h87);
        expect_byte("cmd8_ncr", 8'hFF);
        expect_byte("cmd8_r1", 8'h01);
        expect_byte("cmd8_b1", 8'h00);
        expect_byte("cmd8_b2", 8'h00);
        expect_byte("cmd8_b3", 8'h01);
        expect_byte("cmd8_b4", 8'hAA);

        send_cmd(6'd17, 32'd3, 8'hFF);
        expect_byte("rd_uninit_ncr", 8'hFF);
        expect_byte("rd_uninit_r1", 8'h05);
        for (int i = 0; i < 4; i++) expect_byte("rd_uninit_notoken", 8'hFF);

        init_card();

        send_cmd(6'd58, 32'h0, 8'hFF);
        expect_byte("cmd58_ncr", 8'hFF);
        expect_byte("cmd58_r1", 8'h00);
        expect_byte("ocr0", 8'hC0);
        expect_byte("ocr1", 8'hFF);
        expect_byte("ocr2", 8'h80);
        expect_byte("ocr3", 8'h00);

        send_cmd(6'd5, 32'h0, 8'hFF);
        expect_byte("cmd5_ncr", 8'hFF);
        expect_byte("cmd5_r1", 8'h04);

        send_cmd(6'd24, 32'd3, 8'hFF);
        expect_byte("wr_ncr", 8'hFF);
        expect_byte("wr_r1", 8'h00);
        expect_byte("wr_token_wait", 8'hFF);
        xfer(8'hFE, 8, rx);
        for (int i = 0; i < 512; i++) xfer(8'(i), 8, rx);
        xfer(8'hAB, 8, rx);
        xfer(8'hCD, 8, rx);
        expect_byte("wr_dresp", 8'h05);
        for (int i = 0; i < 4; i++) expect_byte("wr_busy", 8'h00);
        expect_byte("wr_done", 8'hFF);

        read_head();
        for (int i = 0; i < 512; i++) expect_byte("rd_data", 8'(i));
        expect_byte("rd_crc0", 8'hFF);
        expect_byte("rd_crc1", 8'hFF);
        expect_byte("rd_idle", 8'hFF);

        // clear drops initialization but keeps the stored block
        @(negedge clk); clear = 1'b1;
        repeat (2) @(negedge clk); clear = 1'b0;
        repeat (2) @(negedge clk);
        send_cmd(6'd17, 32'd3, 8'hFF);
        expect_byte("clr_rd_ncr", 8'hFF);
        expect_byte("clr_rd_r1", 8'h05);
        init_card();

        read_head();
        for (int i = 0; i < 100; i++) expect_byte("abort_data", 8'(i));
        xfer(8'hFF, 4, rx);
        sdCS = 1'b1;
        repeat (4) @(negedge clk);
        chk("desel_miso", {7'd0, sdMISO}, 8'h01);
        xfer(8'hFF, 8, rx);
        chk("desel_byte", rx, 8'hFF);
        sdCS = 1'b0;
        repeat (4) @(negedge clk);
        send_cmd(6'd0, 32'h0, 8'h95);
        expect_byte("recmd0_ncr", 8'hFF);
        expect_byte("recmd0_r1", 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
